score_keeper: RTL

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/score_keeper.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/score_keeper.sv
// score_keeper: two-player goal counter with BCD display outputs, lockout and win detection.
// Optional feature: define SCORE_WIN_BY_TWO_EN to require a two-goal lead at or above WIN_SCORE.
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   p1_goal     puck-in-goal level credited to player 1
//   p2_goal     puck-in-goal level credited to player 2
//   new_game    synchronous clear/restart request
//   p1_ones     player 1 units digit (BCD)
//   p1_tens     player 1 tens digit
//   p2_ones     player 2 units digit (BCD)
//   p2_tens     player 2 tens digit
//   score_event one-cycle pulse when a new score appears
//   game_over   high while the game is finished
//   winner      00 none, 01 player 1, 10 player 2
module score_keeper #(
    parameter int WIN_SCORE      = 7,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       p1_goal,
    input  logic       p2_goal,
    input  logic       new_game,
    output logic [3:0] p1_ones,
    output logic [2:0] p1_tens,
    output logic [3:0] p2_ones,
    output logic [2:0] p2_tens,
    output logic       score_event,
    output logic       game_over,
    output logic [1:0] winner
);
    typedef enum logic [1:0] {PLAY, LOCKOUT, OVER} state_t;

    localparam logic [6:0]  WIN       = 7'(WIN_SCORE);
    localparam logic [15:0] LOCK_LAST = 16'(LOCKOUT_CYCLES - 1);

    state_t      state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic        p1_q, p1_h, p2_q, p2_h;
    logic        p1_edge, p2_edge;
    logic [6:0]  p1_cur, p2_cur, p1_inc, p2_inc, p1_nx, p2_nx;
    logic        p1_wins, p2_wins, go_nx, ev_nx;
    logic [1:0]  win_nx;

    // Scores are kept as {tens, ones}; saturates at 79.
    function automatic logic [6:0] bcd_inc(input logic [6:0] s);
        return s == 7'h79 ? s : (s[3:0] == 4'd9 ? {s[6:4] + 3'd1, 4'd0} : {s[6:4], s[3:0] + 4'd1});
    endfunction

    function automatic logic [6:0] to_bin(input logic [6:0] s);
        return {4'b0, s[6:4]} * 7'd10 + {3'b0, s[3:0]};
    endfunction

    function automatic logic wins(input logic [6:0] scorer, input logic [6:0] opp);
`ifdef SCORE_WIN_BY_TWO_EN
        return scorer >= WIN && scorer >= opp + 7'd2;
`else
        return scorer == WIN;
`endif
    endfunction

    assign p1_cur  = {p1_tens, p1_ones};
    assign p2_cur  = {p2_tens, p2_ones};
    assign p1_edge = p1_q & ~p1_h;
    assign p2_edge = p2_q & ~p2_h;
    assign p1_inc  = bcd_inc(p1_cur);
    assign p2_inc  = bcd_inc(p2_cur);
    assign p1_wins = wins(to_bin(p1_inc), to_bin(p2_cur));
    assign p2_wins = wins(to_bin(p2_inc), to_bin(p1_cur));

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        p1_nx    = p1_cur;
        p2_nx    = p2_cur;
        go_nx    = game_over;
        win_nx   = winner;
        ev_nx    = 1'b0;
        if (new_game) begin
            state_nx = PLAY;
            cnt_nx   = '0;
            p1_nx    = '0;
            p2_nx    = '0;
            go_nx    = 1'b0;
            win_nx   = 2'b00;
        end else begin
            case (state)
                PLAY: begin
                    // Simultaneous edges on both inputs are discarded.
                    if (p1_edge ^ p2_edge) begin
                        ev_nx = 1'b1;
                        p1_nx = p1_edge ? p1_inc : p1_cur;
                        p2_nx = p2_edge ? p2_inc : p2_cur;
                        if (p1_edge ? p1_wins : p2_wins) begin
                            state_nx = OVER;
                            go_nx    = 1'b1;
                            win_nx   = p1_edge ? 2'b01 : 2'b10;
                        end else begin
                            state_nx = LOCKOUT;
                            cnt_nx   = LOCK_LAST;
                        end
                    end
                end
                LOCKOUT: begin
                    state_nx = cnt == '0 ? PLAY : LOCKOUT;
                    cnt_nx   = cnt == '0 ? cnt : cnt - 16'd1;
                end
                OVER:    state_nx = OVER;
                default: state_nx = PLAY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= PLAY;
            cnt         <= '0;
            p1_q        <= 1'b1;
            p1_h        <= 1'b1;
            p2_q        <= 1'b1;
            p2_h        <= 1'b1;
            p1_tens     <= '0;
            p1_ones     <= '0;
            p2_tens     <= '0;
            p2_ones     <= '0;
            score_event <= 1'b0;
            game_over   <= 1'b0;
            winner      <= 2'b00;
        end else begin
            state                <= state_nx;
            cnt                  <= cnt_nx;
            // Edge history runs in every state so a held goal is never re-credited.
            p1_q                 <= p1_goal;
            p1_h                 <= p1_q;
            p2_q                 <= p2_goal;
            p2_h                 <= p2_q;
            {p1_tens, p1_ones}   <= p1_nx;
            {p2_tens, p2_ones}   <= p2_nx;
            score_event          <= ev_nx;
            game_over            <= go_nx;
            winner               <= win_nx;
        end
    end
endmodule
